// File: rtl/bmu_modport.sv
// bmu_modport: single-cycle bit-manipulation / ALU execute unit.
// Decodes a one-hot op packet and registers the result together with an
// illegal-operation flag. Covers the base ALU ops plus Zba/Zbb/Zbs.
//
// Build option: define BMU_ZBB_EN to implement the Zbb ops (clz, ctz, cpop,
// siext_b/h, min/max, pack/packu/packh, rol/ror, grev/gorc and the zbb
// inverted-operand logic forms). Without it those ops report illegal.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rstL       in   1  asynchronous active-low reset
//   scanMode   in   1  DFT scan indicator (no clock gating here, no effect)
//   validIn    in   1  operation valid this cycle
//   ap         in  42  one-hot op packet (clz at bit 41 ... csr_imm at bit 0)
//   csrRenIn   in   1  substitute CSR read data for operand A
//   csrRdataIn in  32  CSR read data
//   aIn        in  32  operand A
//   bIn        in  32  operand B / immediate
//   resultFf   out 32  registered result
//   error      out  1  registered illegal-operation flag
module bmu_modport (
   input  logic        clk,
   input  logic        rstL,
   input  logic        scanMode,
   input  logic        validIn,
   input  logic [41:0] ap,
   input  logic        csrRenIn,
   input  logic [31:0] csrRdataIn,
   input  logic [31:0] aIn,
   input  logic [31:0] bIn,
   output logic [31:0] resultFf,
   output logic        error
);

   localparam int AP_CLZ = 41, AP_CTZ = 40, AP_CPOP = 39, AP_SEXTB = 38, AP_SEXTH = 37;
   localparam int AP_MIN = 36, AP_MAX = 35, AP_PACK = 34, AP_PACKU = 33, AP_PACKH = 32;
   localparam int AP_ROL = 31, AP_ROR = 30, AP_GREV = 29, AP_GORC = 28, AP_ZBB = 27;
   localparam int AP_BSET = 26, AP_BCLR = 25, AP_BINV = 24, AP_BEXT = 23;
   localparam int AP_SH1 = 22, AP_SH2 = 21, AP_SH3 = 20, AP_ZBA = 19;
   localparam int AP_AND = 18, AP_OR = 17, AP_XOR = 16, AP_SLL = 15, AP_SRL = 14, AP_SRA = 13;
   localparam int AP_ADD = 8, AP_SUB = 7, AP_SLT = 6, AP_UNSIGN = 5;
   localparam int AP_CSRW = 1, AP_CSRIMM = 0;

   logic [31:0] a_op, b_op, b_log, op_res, onehot;
   logic [4:0]  sh;
   logic [30:0] prim;
   logic        lt, zba_bad, zbb_illegal, illegal;
   logic [31:0] result_q, result_d;
   logic        error_q, error_d;
   logic        unused_bits;

   // Branch/jump/predict bits and scanMode have no effect on this unit.
   assign unused_bits = ^{scanMode, ap[12:9], ap[4:2]};

   assign a_op = csrRenIn ? csrRdataIn : aIn;
   assign b_op = bIn;
   assign sh   = bIn[4:0];
   assign onehot = 32'b1 << sh;

   // Everything except modifiers (zbb, zba, unsign, csr_imm) and ignored bits.
   assign prim    = {ap[41:28], ap[26:20], ap[18:13], ap[8:6], ap[AP_CSRW]};
   assign zba_bad = ap[AP_ZBA] & ~(|ap[AP_SH1:AP_SH3]);

`ifdef BMU_ZBB_EN
   assign zbb_illegal = 1'b0;
   assign b_log       = ap[AP_ZBB] ? ~b_op : b_op;
`else
   assign zbb_illegal = |ap[AP_CLZ:AP_ZBB];
   assign b_log       = b_op;
`endif

   assign illegal = ($countones(prim) != 1) | zba_bad | zbb_illegal;
   assign lt      = ap[AP_UNSIGN] ? (a_op < b_op) : ($signed(a_op) < $signed(b_op));

`ifdef BMU_ZBB_EN
   function automatic logic [5:0] f_clz(input logic [31:0] v);
      logic [5:0] n;
      n = 6'd32;
      for (int i = 0; i < 32; i++) if (v[i]) n = 6'(31 - i);
      return n;
   endfunction

   function automatic logic [5:0] f_ctz(input logic [31:0] v);
      logic [5:0] n;
      n = 6'd32;
      for (int i = 31; i >= 0; i--) if (v[i]) n = 6'(i);
      return n;
   endfunction

   // One butterfly stage per shift-amount bit; orc keeps the original bits.
   function automatic logic [31:0] f_stage(input logic [31:0] x, input logic [31:0] m,
                                           input int d, input logic orc);
      logic [31:0] y;
      y = ((x & m) << d) | ((x & ~m) >> d);
      return orc ? (x | y) : y;
   endfunction

   function automatic logic [31:0] f_grev(input logic [31:0] v, input logic [4:0] s,
                                          input logic orc);
      logic [31:0] x;
      x = v;
      if (s[0]) x = f_stage(x, 32'h5555_5555, 1, orc);
      if (s[1]) x = f_stage(x, 32'h3333_3333, 2, orc);
      if (s[2]) x = f_stage(x, 32'h0F0F_0F0F, 4, orc);
      if (s[3]) x = f_stage(x, 32'h00FF_00FF, 8, orc);
      if (s[4]) x = f_stage(x, 32'h0000_FFFF, 16, orc);
      return x;
   endfunction
`endif

   always_comb begin
      logic [63:0] rot;
      op_res = 32'b0;
      rot    = 64'b0;
      if (ap[AP_ADD])       op_res = a_op + b_op;
      else if (ap[AP_SUB])  op_res = a_op - b_op;
      else if (ap[AP_SLT])  op_res = {31'b0, lt};
      else if (ap[AP_AND])  op_res = a_op & b_log;
      else if (ap[AP_OR])   op_res = a_op | b_log;
      else if (ap[AP_XOR])  op_res = a_op ^ b_log;
      else if (ap[AP_SLL])  op_res = a_op << sh;
      else if (ap[AP_SRL])  op_res = a_op >> sh;
      else if (ap[AP_SRA])  op_res = 32'($signed(a_op) >>> sh);
      else if (ap[AP_SH1])  op_res = (a_op << 1) + b_op;
      else if (ap[AP_SH2])  op_res = (a_op << 2) + b_op;
      else if (ap[AP_SH3])  op_res = (a_op << 3) + b_op;
      else if (ap[AP_BSET]) op_res = a_op | onehot;
      else if (ap[AP_BCLR]) op_res = a_op & ~onehot;
      else if (ap[AP_BINV]) op_res = a_op ^ onehot;
      else if (ap[AP_BEXT]) op_res = {31'b0, a_op[sh]};
      else if (ap[AP_CSRW]) op_res = ap[AP_CSRIMM] ? b_op : a_op;
`ifdef BMU_ZBB_EN
      else if (ap[AP_CLZ])   op_res = {26'b0, f_clz(a_op)};
      else if (ap[AP_CTZ])   op_res = {26'b0, f_ctz(a_op)};
      else if (ap[AP_CPOP])  op_res = {26'b0, 6'($countones(a_op))};
      else if (ap[AP_SEXTB]) op_res = {{24{a_op[7]}}, a_op[7:0]};
      else if (ap[AP_SEXTH]) op_res = {{16{a_op[15]}}, a_op[15:0]};
      else if (ap[AP_MIN])   op_res = lt ? a_op : b_op;
      else if (ap[AP_MAX])   op_res = lt ? b_op : a_op;
      else if (ap[AP_PACK])  op_res = {b_op[15:0], a_op[15:0]};
      else if (ap[AP_PACKU]) op_res = {b_op[31:16], a_op[31:16]};
      else if (ap[AP_PACKH]) op_res = {16'b0, b_op[7:0], a_op[7:0]};
      else if (ap[AP_ROL]) begin
         rot    = {a_op, a_op} << sh;
         op_res = rot[63:32];
      end
      else if (ap[AP_ROR]) begin
         rot    = {a_op, a_op} >> sh;
         op_res = rot[31:0];
      end
      else if (ap[AP_GREV])  op_res = f_grev(a_op, sh, 1'b0);
      else if (ap[AP_GORC])  op_res = f_grev(a_op, sh, 1'b1);
`endif
   end

   always_comb begin
      result_d = result_q;
      error_d  = 1'b0;
      if (validIn) begin
         result_d = illegal ? 32'b0 : op_res;
         error_d  = illegal;
      end
   end

   always_ff @(posedge clk or negedge rstL) begin
      if (!rstL) begin
         result_q <= 32'b0;
         error_q  <= 1'b0;
      end else begin
         result_q <= result_d;
         error_q  <= error_d;
      end
   end

   assign resultFf = result_q;
   assign error    = error_q;

endmodule

// File: tb/tb_bmu_modport.sv
module tb_bmu_modport;

   localparam int I_CLZ = 41, I_CTZ = 40, I_CPOP = 39, I_SEXTB = 38, I_SEXTH = 37;
   localparam int I_MIN = 36, I_MAX = 35, I_PACK = 34, I_PACKU = 33, I_PACKH = 32;
   localparam int I_ROL = 31, I_ROR = 30, I_GREV = 29, I_GORC = 28, I_ZBB = 27;
   localparam int I_BSET = 26, I_BCLR = 25, I_BINV = 24, I_BEXT = 23;
   localparam int I_SH1 = 22, I_SH2 = 21, I_SH3 = 20, I_ZBA = 19;
   localparam int I_AND = 18, I_OR = 17, I_XOR = 16, I_SLL = 15, I_SRL = 14, I_SRA = 13;
   localparam int I_ADD = 8, I_SUB = 7, I_SLT = 6, I_UNSIGN = 5;
   localparam int I_CSRW = 1, I_CSRIMM = 0;
`ifdef BMU_ZBB_EN
   localparam bit ZBB_ON = 1'b1;
`else
   localparam bit ZBB_ON = 1'b0;
`endif

   logic        clk, rstL, scanMode, validIn, csrRenIn;
   logic [41:0] ap;
   logic [31:0] csrRdataIn, aIn, bIn, resultFf;
   logic        error;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_res = 32'b0;
   logic        exp_err = 1'b0;

   int prim_list[31] = '{41, 40, 39, 38, 37, 36, 35, 34, 33, 32, 31, 30, 29, 28,
                         26, 25, 24, 23, 22, 21, 20, 18, 17, 16, 15, 14, 13, 8, 7, 6, 1};

   bmu_modport dut (
      .clk(clk), .rstL(rstL), .scanMode(scanMode), .validIn(validIn), .ap(ap),
      .csrRenIn(csrRenIn), .csrRdataIn(csrRdataIn), .aIn(aIn), .bIn(bIn),
      .resultFf(resultFf), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [41:0] op(input int idx);
      return 42'd1 << idx;
   endfunction

   function automatic bit is_nonprim(input int i);
      return i inside {27, 19, 5, 0, 12, 11, 10, 9, 4, 3, 2};
   endfunction

   // Reference: {error, result} for a valid op, computed bit by bit from the rules.
   function automatic logic [32:0] model(input logic [41:0] p, input logic [31:0] a,
                                         input logic [31:0] b);
      int n, idx, sh;
      logic [31:0] r, bb;
      bit less;
      n = 0; idx = -1; r = 32'b0;
      for (int i = 0; i < 42; i++) if (p[i] && !is_nonprim(i)) begin n++; idx = i; end
      if (n != 1) return {1'b1, 32'b0};
      if (p[I_ZBA] && !(idx inside {I_SH1, I_SH2, I_SH3})) return {1'b1, 32'b0};
      if (!ZBB_ON) for (int i = 27; i < 42; i++) if (p[i]) return {1'b1, 32'b0};
      sh   = int'(b[4:0]);
      bb   = p[I_ZBB] ? ~b : b;
      less = p[I_UNSIGN] ? (a < b) : ($signed(a) < $signed(b));
      case (idx)
         I_ADD:   r = a + b;
         I_SUB:   r = a - b;
         I_SLT:   r = less ? 32'd1 : 32'd0;
         I_AND:   r = a & bb;
         I_OR:    r = a | bb;
         I_XOR:   r = a ^ bb;
         I_SLL:   for (int i = 0; i < 32; i++) r[i] = (i >= sh) ? a[i - sh] : 1'b0;
         I_SRL:   for (int i = 0; i < 32; i++) r[i] = (i + sh < 32) ? a[i + sh] : 1'b0;
         I_SRA:   for (int i = 0; i < 32; i++) r[i] = (i + sh < 32) ? a[i + sh] : a[31];
         I_ROL:   for (int i = 0; i < 32; i++) r[(i + sh) % 32] = a[i];
         I_ROR:   for (int i = 0; i < 32; i++) r[i] = a[(i + sh) % 32];
         I_SH1:   r = a * 2 + b;
         I_SH2:   r = a * 4 + b;
         I_SH3:   r = a * 8 + b;
         I_CLZ:   begin n = 0; for (int i = 31; i >= 0; i--) begin if (a[i]) break; n++; end r = n; end
         I_CTZ:   begin n = 0; for (int i = 0; i < 32; i++) begin if (a[i]) break; n++; end r = n; end
         I_CPOP:  begin n = 0; for (int i = 0; i < 32; i++) n += int'(a[i]); r = n; end
         I_SEXTB: r = a[7] ? (32'hFFFF_FF00 | a[7:0]) : {24'b0, a[7:0]};
         I_SEXTH: r = a[15] ? (32'hFFFF_0000 | a[15:0]) : {16'b0, a[15:0]};
         I_MIN:   r = less ? a : b;
         I_MAX:   r = less ? b : a;
         I_PACK:  r = (b << 16) | (a & 32'hFFFF);
         I_PACKU: r = (b & 32'hFFFF_0000) | (a >> 16);
         I_PACKH: r = ((b & 32'hFF) << 8) | (a & 32'hFF);
         I_GREV:  for (int i = 0; i < 32; i++) r[i] = a[i ^ sh];
         I_GORC:  for (int i = 0; i < 32; i++)
                     for (int j = 0; j < 32; j++)
                        if (((i ^ j) & ~sh & 31) == 0) r[i] = r[i] | a[j];
         I_BSET:  begin r = a; r[sh] = 1'b1; end
         I_BCLR:  begin r = a; r[sh] = 1'b0; end
         I_BINV:  begin r = a; r[sh] = ~a[sh]; end
         I_BEXT:  r = a[sh] ? 32'd1 : 32'd0;
         I_CSRW:  r = p[I_CSRIMM] ? b : a;
         default: r = 32'b0;
      endcase
      return {1'b0, r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Apply one cycle of stimulus, update the reference, compare both outputs.
   task automatic drive(input string tag, input logic v, input logic [41:0] p,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic cren, input logic [31:0] crd);
      logic [32:0] m;
      validIn = v; ap = p; aIn = a; bIn = b; csrRenIn = cren; csrRdataIn = crd;
      @(posedge clk); #1;
      if (v) begin
         m = model(p, cren ? crd : a, b);
         exp_err = m[32];
         exp_res = m[31:0];
      end else begin
         exp_err = 1'b0;
      end
      chk({tag, ".res"}, resultFf, exp_res);
      chk({tag, ".err"}, {31'b0, error}, {31'b0, exp_err});
   endtask

   // Directed step: also checks against the literal value worked out by hand.
   task automatic dir(input string tag, input logic [41:0] p, input logic [31:0] a,
                      input logic [31:0] b, input logic cren, input logic [31:0] crd,
                      input logic [31:0] want, input bit zbb_op);
      drive(tag, 1'b1, p, a, b, cren, crd);
      if (zbb_op && !ZBB_ON) begin
         chk({tag, ".lit_res"}, resultFf, 32'b0);
         chk({tag, ".lit_err"}, {31'b0, error}, 32'd1);
      end else begin
         chk({tag, ".lit_res"}, resultFf, want);
         chk({tag, ".lit_err"}, {31'b0, error}, 32'd0);
      end
   endtask

   initial begin
      logic [41:0] p;
      logic [31:0] a, b, crd;
      logic        v, cren;
      int          k, sel;

      rstL = 1'b0; scanMode = 1'b0; validIn = 1'b0; ap = '0;
      csrRenIn = 1'b0; csrRdataIn = '0; aIn = '0; bIn = '0;
      #12;
      chk("reset.res", resultFf, 32'b0);
      chk("reset.err", {31'b0, error}, 32'd0);
      rstL = 1'b1;
      drive("idle0", 1'b0, '0, 32'h1234, 32'h5678, 1'b0, '0);
      dir("add_small", op(I_ADD), 32'd5, 32'd7, 1'b0, '0, 32'd12, 1'b0);

      // Asynchronous reset between edges clears the outputs immediately.
      #3 rstL = 1'b0;
      #1;
      chk("async_rst.res", resultFf, 32'b0);
      chk("async_rst.err", {31'b0, error}, 32'd0);
      @(posedge clk); #1;
      rstL = 1'b1;
      exp_res = 32'b0; exp_err = 1'b0;
      drive("idle1", 1'b0, op(I_ADD), 32'hFFFF, 32'h1, 1'b0, '0);

      dir("add_wrap", op(I_ADD), 32'hFFFF_FFFF, 32'd1, 1'b0, '0, 32'h0, 1'b0);
      dir("slt_s", op(I_SLT), 32'h8000_0000, 32'd1, 1'b0, '0, 32'd1, 1'b0);
      dir("slt_u", op(I_SLT) | op(I_UNSIGN), 32'h8000_0000, 32'd1, 1'b0, '0, 32'd0, 1'b0);
      dir("sra", op(I_SRA), 32'h8000_0000, 32'd4, 1'b0, '0, 32'hF800_0000, 1'b0);
      dir("ror", op(I_ROR), 32'h1, 32'd1, 1'b0, '0, 32'h8000_0000, 1'b1);
      dir("sh3add", op(I_SH3) | op(I_ZBA), 32'd2, 32'd5, 1'b0, '0, 32'd21, 1'b0);
      dir("clz0", op(I_CLZ), 32'h0, 32'h0, 1'b0, '0, 32'd32, 1'b1);
      dir("ctz", op(I_CTZ), 32'h100, 32'h0, 1'b0, '0, 32'd8, 1'b1);
      dir("cpop", op(I_CPOP), 32'hF0F0_F0F0, 32'h0, 1'b0, '0, 32'd16, 1'b1);
      dir("rev8", op(I_GREV), 32'h1122_3344, 32'd24, 1'b0, '0, 32'h4433_2211, 1'b1);
      dir("andn", op(I_AND) | op(I_ZBB), 32'hFF, 32'h0F, 1'b0, '0, 32'hF0, 1'b1);
      dir("csr_bset", op(I_BSET), 32'hDEAD_BEEF, 32'd8, 1'b1, 32'hA5, 32'h1A5, 1'b0);
      dir("csrw_imm", op(I_CSRW) | op(I_CSRIMM), 32'h7777, 32'h12, 1'b0, '0, 32'h12, 1'b0);

      drive("two_ops", 1'b1, op(I_ADD) | op(I_SUB), 32'd3, 32'd4, 1'b0, '0);
      chk("two_ops.lit_err", {31'b0, error}, 32'd1);
      chk("two_ops.lit_res", resultFf, 32'd0);
      drive("after_err", 1'b0, '0, 32'd3, 32'd4, 1'b0, '0);
      chk("after_err.lit_err", {31'b0, error}, 32'd0);
      chk("after_err.lit_res", resultFf, 32'd0);

      for (int it = 0; it < 400; it++) begin
         sel  = $urandom_range(0, 11);
         k    = prim_list[$urandom_range(0, 30)];
         a    = $urandom;
         b    = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
         crd  = $urandom;
         cren = ($urandom_range(0, 3) == 0);
         v    = (sel != 0);
         p    = op(k);
         if (sel == 1) p = p | op(prim_list[$urandom_range(0, 30)]);
         if (sel == 2) p = '0;
         if (sel == 3) p = p | op(I_ZBA);
         if (k inside {I_SH1, I_SH2, I_SH3}) p = p | op(I_ZBA);
         if (k inside {I_AND, I_OR, I_XOR} && $urandom_range(0, 1) == 1) p = p | op(I_ZBB);
         if ($urandom_range(0, 1) == 1) p = p | op(I_UNSIGN);
         if ($urandom_range(0, 1) == 1) p = p | op(I_CSRIMM);
         if ($urandom_range(0, 3) == 0) p = p | (42'($urandom) & 42'h0000_0001E1C);
         drive("rand", v, p, a, b, cren, crd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
